// File: rtl/rf_sp_nx32m2.sv
// -----------------------------------------------------------------------------
// rf_sp_nx32m2
//
// Behavioural single-port register file, NumWords x 32 bits, mux-2 column
// organisation. Stands in for the rf64x32m2 / rf128x32m2 / rf256x32m2 hard
// macros used by the SRAM wrapper for its small banks.
//
// Parameters
//   NumWords   number of 32-bit words (64, 128 or 256)
//   AddrWidth  $clog2(NumWords), derived
//
// Ports
//   clk_i, rst_ni      rising-edge clock; async active-low reset (clears Q, SO)
//   CEN, GWEN, WEN     functional chip enable / global write enable / per-bit
//                      write enable, all active low
//   A, D               functional address / write data
//   EMA, EMAW          timing-margin pins, accepted and ignored
//   TEN                test-mode select, active low (0 selects the T* inputs)
//   TCEN, TGWEN, TWEN  test-mode counterparts of CEN, GWEN, WEN
//   TA, TD             test-mode counterparts of A, D
//   RET1N              retention, active low; 0 freezes array and Q
//   SI, SE, SO         2-bit scan stub: SO <= SI on each edge while SE=1
//   DFTRAMBYP          RAM bypass: with cen=0, Q <= d and the array is untouched
//   Q                  registered read data (1-cycle latency)
//   CENY, GWENY, WENY, AY  muxed effective controls, purely combinational
//
// Handshake: there is none. Each rising edge with an enabled access performs
// exactly one operation; the result of a read/bypass is on Q after that edge
// and is held until the next read or bypass.
// -----------------------------------------------------------------------------
module rf_sp_nx32m2 #(
    parameter  int NumWords  = 128,
    localparam int AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 CEN,
    input  logic                 GWEN,
    input  logic [31:0]          WEN,
    input  logic [AddrWidth-1:0] A,
    input  logic [31:0]          D,
    input  logic [2:0]           EMA,
    input  logic [1:0]           EMAW,
    input  logic                 TEN,
    input  logic                 TCEN,
    input  logic                 TGWEN,
    input  logic [31:0]          TWEN,
    input  logic [AddrWidth-1:0] TA,
    input  logic [31:0]          TD,
    input  logic                 RET1N,
    input  logic [1:0]           SI,
    input  logic                 SE,
    input  logic                 DFTRAMBYP,
    output logic [31:0]          Q,
    output logic                 CENY,
    output logic                 GWENY,
    output logic [31:0]          WENY,
    output logic [AddrWidth-1:0] AY,
    output logic [1:0]           SO
);

    // ------------------------------------------------------------------
    // Input mux: TEN=1 functional inputs, TEN=0 test inputs.
    // ------------------------------------------------------------------
    logic                 w_cen;
    logic                 w_gwen;
    logic [31:0]          w_wen;
    logic [AddrWidth-1:0] w_a;
    logic [31:0]          w_d;

    assign w_cen  = TEN ? CEN  : TCEN;
    assign w_gwen = TEN ? GWEN : TGWEN;
    assign w_wen  = TEN ? WEN  : TWEN;
    assign w_a    = TEN ? A    : TA;
    assign w_d    = TEN ? D    : TD;

    // Y outputs mirror the selected controls with no register stage, so they
    // stay valid through reset.
    assign CENY  = w_cen;
    assign GWENY = w_gwen;
    assign WENY  = w_wen;
    assign AY    = w_a;

    // Margin pins have no behavioural meaning in this model.
    logic w_unused_margin;
    assign w_unused_margin = ^{EMA, EMAW};

    // ------------------------------------------------------------------
    // Access decode. Priority: retention > bypass > read/write.
    // ------------------------------------------------------------------
    logic w_active;
    logic w_bypass;
    logic w_read;
    logic w_write;

    assign w_active = RET1N && !w_cen;
    assign w_bypass = w_active &&  DFTRAMBYP;
    assign w_read   = w_active && !DFTRAMBYP &&  w_gwen;
    assign w_write  = w_active && !DFTRAMBYP && !w_gwen;

    // ------------------------------------------------------------------
    // Storage array. Not reset; edges seen while rst_ni=0 are ignored so an
    // access in flight at reset assertion never lands.
    // ------------------------------------------------------------------
    logic [31:0] r_mem [NumWords];

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_write) begin
            // Bits with wen=0 take d, bits with wen=1 keep their old value.
            r_mem[w_a] <= (r_mem[w_a] & w_wen) | (w_d & ~w_wen);
        end
    end

    // ------------------------------------------------------------------
    // Read data register.
    // ------------------------------------------------------------------
    logic [31:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= 32'h0;
        end else if (w_bypass) begin
            r_q <= w_d;
        end else if (w_read) begin
            r_q <= r_mem[w_a];
        end
    end

    assign Q = r_q;

    // ------------------------------------------------------------------
    // Scan stub: independent of the array and Q.
    // ------------------------------------------------------------------
    logic [1:0] r_so;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_so <= 2'b00;
        end else if (SE) begin
            r_so <= SI;
        end
    end

    assign SO = r_so;

endmodule

// File: tb/tb_rf_sp_nx32m2.sv
// -----------------------------------------------------------------------------
// tb_rf_sp_nx32m2
//
// Directed bench for rf_sp_nx32m2. The main instance uses NumWords=128; two
// extra instances (64 and 256 words) share data/control inputs but have their
// own CEN and address so they stay idle unless addressed directly.
// -----------------------------------------------------------------------------
module tb_rf_sp_nx32m2;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- shared stimulus ----------------
    logic        CEN = 1'b1;
    logic        GWEN = 1'b1;
    logic [31:0] WEN = '1;
    logic [6:0]  A = '0;
    logic [31:0] D = '0;
    logic        TEN = 1'b1;
    logic        TCEN = 1'b1;
    logic        TGWEN = 1'b1;
    logic [31:0] TWEN = '1;
    logic [6:0]  TA = '0;
    logic [31:0] TD = '0;
    logic        RET1N = 1'b1;
    logic [1:0]  SI = '0;
    logic        SE = 1'b0;
    logic        DFTRAMBYP = 1'b0;

    logic [31:0] Q;
    logic        CENY;
    logic        GWENY;
    logic [31:0] WENY;
    logic [6:0]  AY;
    logic [1:0]  SO;

    // 64-word instance
    logic        cen64 = 1'b1;
    logic [5:0]  a64 = '0;
    logic [31:0] q64;
    logic        ceny64, gweny64;
    logic [31:0] weny64;
    logic [5:0]  ay64;
    logic [1:0]  so64;

    // 256-word instance
    logic        cen256 = 1'b1;
    logic [7:0]  a256 = '0;
    logic [31:0] q256;
    logic        ceny256, gweny256;
    logic [31:0] weny256;
    logic [7:0]  ay256;
    logic [1:0]  so256;

    rf_sp_nx32m2 #(.NumWords(128)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
        .A(A), .D(D), .EMA(3'd2), .EMAW(2'd1), .TEN(TEN), .TCEN(TCEN),
        .TGWEN(TGWEN), .TWEN(TWEN), .TA(TA), .TD(TD), .RET1N(RET1N),
        .SI(SI), .SE(SE), .DFTRAMBYP(DFTRAMBYP), .Q(Q), .CENY(CENY),
        .GWENY(GWENY), .WENY(WENY), .AY(AY), .SO(SO)
    );

    rf_sp_nx32m2 #(.NumWords(64)) u_dut64 (
        .clk_i(clk_i), .rst_ni(rst_ni), .CEN(cen64), .GWEN(GWEN), .WEN(WEN),
        .A(a64), .D(D), .EMA(3'd0), .EMAW(2'd0), .TEN(1'b1), .TCEN(1'b1),
        .TGWEN(1'b1), .TWEN('1), .TA(6'd0), .TD(32'h0), .RET1N(1'b1),
        .SI(2'b00), .SE(1'b0), .DFTRAMBYP(1'b0), .Q(q64), .CENY(ceny64),
        .GWENY(gweny64), .WENY(weny64), .AY(ay64), .SO(so64)
    );

    rf_sp_nx32m2 #(.NumWords(256)) u_dut256 (
        .clk_i(clk_i), .rst_ni(rst_ni), .CEN(cen256), .GWEN(GWEN), .WEN(WEN),
        .A(a256), .D(D), .EMA(3'd7), .EMAW(2'd3), .TEN(1'b1), .TCEN(1'b1),
        .TGWEN(1'b1), .TWEN('1), .TA(8'd0), .TD(32'h0), .RET1N(1'b1),
        .SI(2'b00), .SE(1'b0), .DFTRAMBYP(1'b0), .Q(q256), .CENY(ceny256),
        .GWENY(gweny256), .WENY(weny256), .AY(ay256), .SO(so256)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1, away from the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] data,
                      input logic [31:0] mask);
        CEN = 1'b0; GWEN = 1'b0; A = addr; D = data; WEN = mask;
        tick();
        CEN = 1'b1; GWEN = 1'b1; WEN = '1;
    endtask

    task automatic rd(input string tag, input logic [6:0] addr,
                      input logic [31:0] exp);
        CEN = 1'b0; GWEN = 1'b1; A = addr;
        exp_q.push_back(exp);
        tick();
        CEN = 1'b1;
        check_eq(tag, Q, exp_q.pop_front());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        #2;
        check_eq("rst_q", Q, 32'h0);
        check_eq("rst_so", {30'h0, SO}, 32'h0);
        check_eq("rst_ceny", {31'h0, CENY}, 32'h1);
        tick();
        tick();
        #3 rst_ni = 1'b1;
        tick();

        // Write/read
        wr(7'd5, 32'hDEADBEEF, 32'h0);
        check_eq("q_hold_wr", Q, 32'h0);
        rd("rd_a5", 7'd5, 32'hDEADBEEF);

        // Bit-masked write
        wr(7'd5, 32'h00000000, 32'hFFFF00FF);
        check_eq("q_hold_wr2", Q, 32'hDEADBEEF);
        rd("rd_mask", 7'd5, 32'hDEAD00EF);

        // Idle holds Q
        A = 7'd0;
        tick();
        check_eq("idle_hold", Q, 32'hDEAD00EF);

        // Test-input mux
        A = 7'd3; D = 32'hCAFEF00D;
        TEN = 1'b0; TCEN = 1'b0; TGWEN = 1'b0; TA = 7'd7;
        TD = 32'h12345678; TWEN = '0;
        #1;
        check_eq("ay", {25'h0, AY}, 32'd7);
        check_eq("gweny", {31'h0, GWENY}, 32'h0);
        check_eq("ceny", {31'h0, CENY}, 32'h0);
        check_eq("weny", WENY, 32'h0);
        tick();
        check_eq("q_hold_twr", Q, 32'hDEAD00EF);
        TEN = 1'b1; TCEN = 1'b1; TGWEN = 1'b1; TWEN = '1;
        #1;
        check_eq("ceny_fn", {31'h0, CENY}, 32'h1);
        rd("rd_a7", 7'd7, 32'h12345678);
        rd("rd_a5_b", 7'd5, 32'hDEAD00EF);

        // Retention: write and read both ignored
        RET1N = 1'b0;
        wr(7'd5, 32'hFFFFFFFF, 32'h0);
        CEN = 1'b0; GWEN = 1'b1; A = 7'd7;
        tick();
        CEN = 1'b1;
        check_eq("ret_q_hold", Q, 32'hDEAD00EF);
        RET1N = 1'b1;
        rd("rd_after_ret", 7'd5, 32'hDEAD00EF);

        // Bypass with a write request: Q takes D, array unchanged
        DFTRAMBYP = 1'b1;
        wr(7'd5, 32'hA5A5A5A5, 32'h0);
        check_eq("bypass_q", Q, 32'hA5A5A5A5);
        DFTRAMBYP = 1'b0;
        rd("rd_after_byp", 7'd5, 32'hDEAD00EF);

        // Async reset mid-cycle, write during reset discarded
        #3 rst_ni = 1'b0;
        #1;
        check_eq("async_rst_q", Q, 32'h0);
        #1;
        wr(7'd5, 32'h00000000, 32'h0);
        check_eq("rst_hold_q", Q, 32'h0);
        #3 rst_ni = 1'b1;
        tick();
        rd("rd_post_rst5", 7'd5, 32'hDEAD00EF);
        rd("rd_post_rst7", 7'd7, 32'h12345678);

        // Scan
        SE = 1'b1; SI = 2'b10;
        tick();
        check_eq("so_shift", {30'h0, SO}, 32'h2);
        SE = 1'b0; SI = 2'b01;
        tick();
        check_eq("so_hold", {30'h0, SO}, 32'h2);
        check_eq("scan_q_hold", Q, 32'h12345678);

        // 64-word instance: first and last addresses
        GWEN = 1'b0; WEN = '0;
        cen64 = 1'b0; a64 = 6'd0;  D = 32'h11112222; tick();
        a64 = 6'd63; D = 32'h3F3F0063; tick();
        GWEN = 1'b1; WEN = '1;
        a64 = 6'd0;  tick(); check_eq("n64_a0", q64, 32'h11112222);
        a64 = 6'd63; tick(); check_eq("n64_a63", q64, 32'h3F3F0063);
        cen64 = 1'b1;

        // 256-word instance: first and last addresses
        GWEN = 1'b0; WEN = '0;
        cen256 = 1'b0; a256 = 8'd0;   D = 32'h0BADCAFE; tick();
        a256 = 8'd255; D = 32'hFF00FF55; tick();
        GWEN = 1'b1; WEN = '1;
        a256 = 8'd0;   tick(); check_eq("n256_a0", q256, 32'h0BADCAFE);
        a256 = 8'd255; tick(); check_eq("n256_a255", q256, 32'hFF00FF55);
        cen256 = 1'b1;

        // Main instance saw none of the small-instance traffic
        rd("main_a0_idle", 7'd7, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_sp_nx32m2.md
# rf_sp_nx32m2

Behavioral single-port register-file macro, 32-bit words with mux-2 column organisation, standing in for the rf64x32m2 / rf128x32m2 / rf256x32m2 hard macros selected by the SRAM wrapper's small-bank cases. It provides synchronous read/write with per-bit active-low write enables. It also provides a test-input mux, retention control, a RAM-bypass DFT path and a 2-bit scan stub. Timing-margin pins are accepted but have no functional effect.

## Interface
- NumWords, 128, number of 32-bit words; legal values 64, 128 and 256.
- AddrWidth, $clog2(NumWords), derived; never overridden.
- clk_i  in  1  rising-edge clock for all sequential logic.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low. It clears Q and SO only; array contents are not reset.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low; 1 = read, 0 = write.
- WEN  in  32  per-bit write enable, active low.
- A  in  AddrWidth  word address.
- D  in  32  write data.
- EMA  in  3  read margin; ignored.
- EMAW  in  2  write margin; ignored.
- TEN  in  1  test-mode enable, active low; 0 selects the T* inputs.
- TCEN  in  1  test-mode CEN.
- TGWEN  in  1  test-mode GWEN.
- TWEN  in  32  test-mode WEN.
- TA  in  AddrWidth  test-mode A.
- TD  in  32  test-mode D.
- RET1N  in  1  retention, active low; 0 = retention mode.
- SI  in  2  scan in.
- SE  in  1  scan enable, active high.
- DFTRAMBYP  in  1  RAM bypass, active high.
- Q  out  32  read data.
- CENY, GWENY  out  1 each  muxed effective CEN and GWEN.
- WENY  out  32  muxed effective WEN.
- AY  out  AddrWidth  muxed effective A.
- SO  out  2  scan out.

## Operation
- Input mux (combinational):
  - TEN=1 selects the functional inputs: CEN, GWEN, WEN, A, D.
  - TEN=0 selects the test inputs: TCEN, TGWEN, TWEN, TA, TD.
  - CENY/GWENY/WENY/AY equal the selected values at all times, including during reset.
- Accesses below use the muxed signals (cen, gwen, wen, a, d).
- Read: cen=0, gwen=1, RET1N=1, DFTRAMBYP=0 → Q ← mem[a] at the clock edge.
- Write: cen=0, gwen=0, RET1N=1, DFTRAMBYP=0.
  - For each bit b with wen[b]=0: mem[a][b] ← d[b]. Other bits are unchanged.
  - Q holds its previous value.
  - wen all ones makes the write a no-op.
- Bypass: DFTRAMBYP=1 and cen=0 → Q ← d on the edge, regardless of gwen. The array is not modified.
- Idle: cen=1 → no array change; Q holds.
- Retention: RET1N=0 → every access is ignored, the array retains its contents, and Q holds. Normal operation resumes on the first edge with RET1N=1.
- Scan:
  - SE=1 → SO ← SI on each edge.
  - SE=0 → SO holds.
  - Scan never touches the array or Q.
- Array is uninitialised (X in simulation) until written.
- Every address in 0..NumWords-1 is valid; no out-of-range case exists.
- Priority per edge: reset > retention > bypass > read/write.

## Timing
- Read latency is 1 cycle: data sampled at edge N is valid on Q after edge N and held until the next read or bypass.
- A write at edge N is visible to a read at edge N+1 or later.
- Single port: one access per cycle; no read-during-write case.
- Async reset: rst_ni falling forces Q=0 and SO=0 immediately.
  - While rst_ni=0, all edges are ignored and the array is not written.
  - An access in flight at reset assertion is discarded.
- Y outputs are purely combinational, with zero latency.

## Test plan
- Write/read, NumWords=128, TEN=1: write A=5 D=0xDEADBEEF with WEN=0, then read A=5 → Q=0xDEADBEEF one cycle later. Q is unchanged during the write cycle.
- Bit mask: after the test above, write A=5 D=0x00000000 with WEN=0xFFFF00FF → read returns 0xDEAD00EF.
- Test mux: TEN=0, TCEN=0, TGWEN=0, TA=7, TD=0x12345678, TWEN=0, with the functional inputs idle → AY=7, GWENY=0. A later functional read of A=7 returns 0x12345678.
- Retention/bypass:
  - RET1N=0 with a write of 0xFFFFFFFF to A=5 → a later read of A=5 (RET1N=1) still returns 0xDEAD00EF.
  - DFTRAMBYP=1, cen=0, D=0xA5A5A5A5 → Q=0xA5A5A5A5, and the array at A is unchanged.
- Reset: after a read that leaves Q=0xDEAD00EF, pull rst_ni low mid-cycle → Q=0 immediately. A write issued during reset does not take effect, and contents written earlier survive.
- Size/scan:
  - NumWords=64 and NumWords=256: write and read back the first and last addresses (0 and NumWords-1) with distinct patterns.
  - SE=1, SI=2'b10 → SO=2'b10 after one edge.
